// File: rtl/axi_pt_pkg.sv
// Shared types and payload-width helpers for the AXI4 passthrough bridge.
// Field order inside each packed payload is fixed by the top-level pack/unpack.
package axi_pt_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    localparam int LEN_W   = 8;
    localparam int SIZE_W  = 3;
    localparam int BURST_W = 2;
    localparam int RESP_W  = 2;
    localparam int CACHE_W = 4;
    localparam int PROT_W  = 3;
    localparam int QOS_W   = 4;

    // AW and AR share one layout: id, addr, len, size, burst, lock, cache, prot, qos
    function automatic int ax_width(input int id_w, input int addr_w);
        return id_w + addr_w + LEN_W + SIZE_W + BURST_W + 1 + CACHE_W + PROT_W + QOS_W;
    endfunction

    function automatic int w_width(input int data_w);
        return data_w + data_w / 8 + 1;
    endfunction

    function automatic int b_width(input int id_w);
        return id_w + RESP_W;
    endfunction

    function automatic int r_width(input int id_w, input int data_w);
        return id_w + data_w + RESP_W + 1;
    endfunction

endpackage

// File: rtl/axi_pt_skid.sv
// Two-entry, full-throughput skid buffer (main register + skid register) for one AXI channel.
// Handshake: a beat moves when valid&ready at a rising edge; valid/data hold until accepted.
module axi_pt_skid
    import axi_pt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid;
    logic             skid_valid;
    logic             ready_q;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    logic push;
    logic pop;
    logic main_valid_nxt;
    logic skid_valid_nxt;
    logic load_main;
    logic load_skid;
    logic main_from_skid;

    assign push = in_valid & ready_q;
    assign pop  = main_valid & out_ready;

    always_comb begin
        main_valid_nxt = main_valid;
        skid_valid_nxt = skid_valid;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (!main_valid || pop) begin
            if (skid_valid) begin
                // Oldest beat advances from skid; a concurrent push refills skid.
                main_from_skid = 1'b1;
                main_valid_nxt = 1'b1;
                skid_valid_nxt = push;
                load_skid      = push;
            end else begin
                main_valid_nxt = push;
                load_main      = push;
            end
        end else if (push) begin
            skid_valid_nxt = 1'b1;
            load_skid      = 1'b1;
        end
    end

    // Ready is a flop so the upstream never sees a combinational path from out_ready.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            main_valid <= main_valid_nxt;
            skid_valid <= skid_valid_nxt;
            ready_q    <= !skid_valid_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (main_from_skid) begin
            main_data <= skid_data;
        end else if (load_main) begin
            main_data <= in_data;
        end
        if (load_skid) begin
            skid_data <= in_data;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: rtl/axi_passthrough_bridge.sv
// AXI4 passthrough: every channel registered through an axi_pt_skid buffer.
// Define AXI_PT_STATS_EN to build the completed-write/read counters; otherwise they read 0.
module axi_passthrough_bridge
    import axi_pt_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                aclk,
    input  logic                areset,
    // upstream AW
    input  logic [ID_W-1:0]     s_awid,
    input  logic [ADDR_W-1:0]   s_awaddr,
    input  logic [7:0]          s_awlen,
    input  logic [2:0]          s_awsize,
    input  logic [1:0]          s_awburst,
    input  logic                s_awlock,
    input  logic [3:0]          s_awcache,
    input  logic [2:0]          s_awprot,
    input  logic [3:0]          s_awqos,
    input  logic                s_awvalid,
    output logic                s_awready,
    // upstream W
    input  logic [DATA_W-1:0]   s_wdata,
    input  logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_wlast,
    input  logic                s_wvalid,
    output logic                s_wready,
    // upstream B
    output logic [ID_W-1:0]     s_bid,
    output logic [1:0]          s_bresp,
    output logic                s_bvalid,
    input  logic                s_bready,
    // upstream AR
    input  logic [ID_W-1:0]     s_arid,
    input  logic [ADDR_W-1:0]   s_araddr,
    input  logic [7:0]          s_arlen,
    input  logic [2:0]          s_arsize,
    input  logic [1:0]          s_arburst,
    input  logic                s_arlock,
    input  logic [3:0]          s_arcache,
    input  logic [2:0]          s_arprot,
    input  logic [3:0]          s_arqos,
    input  logic                s_arvalid,
    output logic                s_arready,
    // upstream R
    output logic [ID_W-1:0]     s_rid,
    output logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          s_rresp,
    output logic                s_rlast,
    output logic                s_rvalid,
    input  logic                s_rready,
    // downstream AW
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_awlock,
    output logic [3:0]          m_awcache,
    output logic [2:0]          m_awprot,
    output logic [3:0]          m_awqos,
    output logic                m_awvalid,
    input  logic                m_awready,
    // downstream W
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    // downstream B
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    // downstream AR
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic                m_arlock,
    output logic [3:0]          m_arcache,
    output logic [2:0]          m_arprot,
    output logic [3:0]          m_arqos,
    output logic                m_arvalid,
    input  logic                m_arready,
    // downstream R
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    // statistics
    output logic [31:0]         wr_done_cnt,
    output logic [31:0]         rd_done_cnt
);

    localparam int AX_PW = ax_width(ID_W, ADDR_W);
    localparam int W_PW  = w_width(DATA_W);
    localparam int B_PW  = b_width(ID_W);
    localparam int R_PW  = r_width(ID_W, DATA_W);

    logic [AX_PW-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [W_PW-1:0]  w_in, w_out;
    logic [B_PW-1:0]  b_in, b_out;
    logic [R_PW-1:0]  r_in, r_out;

    assign aw_in = {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst,
                    s_awlock, s_awcache, s_awprot, s_awqos};
    assign {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst,
            m_awlock, m_awcache, m_awprot, m_awqos} = aw_out;

    assign ar_in = {s_arid, s_araddr, s_arlen, s_arsize, s_arburst,
                    s_arlock, s_arcache, s_arprot, s_arqos};
    assign {m_arid, m_araddr, m_arlen, m_arsize, m_arburst,
            m_arlock, m_arcache, m_arprot, m_arqos} = ar_out;

    assign w_in = {s_wdata, s_wstrb, s_wlast};
    assign {m_wdata, m_wstrb, m_wlast} = w_out;

    assign b_in = {m_bid, m_bresp};
    assign {s_bid, s_bresp} = b_out;

    assign r_in = {m_rid, m_rdata, m_rresp, m_rlast};
    assign {s_rid, s_rdata, s_rresp, s_rlast} = r_out;

    axi_pt_skid #(.WIDTH(AX_PW)) u_aw_skid (
        .aclk(aclk), .areset(areset),
        .in_valid(s_awvalid), .in_ready(s_awready), .in_data(aw_in),
        .out_valid(m_awvalid), .out_ready(m_awready), .out_data(aw_out)
    );

    axi_pt_skid #(.WIDTH(W_PW)) u_w_skid (
        .aclk(aclk), .areset(areset),
        .in_valid(s_wvalid), .in_ready(s_wready), .in_data(w_in),
        .out_valid(m_wvalid), .out_ready(m_wready), .out_data(w_out)
    );

    axi_pt_skid #(.WIDTH(AX_PW)) u_ar_skid (
        .aclk(aclk), .areset(areset),
        .in_valid(s_arvalid), .in_ready(s_arready), .in_data(ar_in),
        .out_valid(m_arvalid), .out_ready(m_arready), .out_data(ar_out)
    );

    // Response channels flow downstream-to-upstream.
    axi_pt_skid #(.WIDTH(B_PW)) u_b_skid (
        .aclk(aclk), .areset(areset),
        .in_valid(m_bvalid), .in_ready(m_bready), .in_data(b_in),
        .out_valid(s_bvalid), .out_ready(s_bready), .out_data(b_out)
    );

    axi_pt_skid #(.WIDTH(R_PW)) u_r_skid (
        .aclk(aclk), .areset(areset),
        .in_valid(m_rvalid), .in_ready(m_rready), .in_data(r_in),
        .out_valid(s_rvalid), .out_ready(s_rready), .out_data(r_out)
    );

`ifdef AXI_PT_STATS_EN
    logic [31:0] wr_cnt;
    logic [31:0] rd_cnt;

    // Completions are counted where the upstream master accepts them.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_cnt <= 32'h0;
            rd_cnt <= 32'h0;
        end else begin
            if (s_bvalid && s_bready) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
            if (s_rvalid && s_rready && s_rlast) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
        end
    end

    assign wr_done_cnt = wr_cnt;
    assign rd_done_cnt = rd_cnt;
`else
    assign wr_done_cnt = 32'h0;
    assign rd_done_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_axi_passthrough_bridge.sv
// Self-checking bench for axi_passthrough_bridge: each channel is modelled as a
// 2-deep FIFO with registered flags; directed scenarios plus randomized traffic.
module tb_axi_passthrough_bridge;
    import axi_pt_pkg::*;

    localparam int PW  = 64;
    localparam int NCH = 5;
    localparam int CH_AW = 0;
    localparam int CH_W  = 1;
    localparam int CH_AR = 2;
    localparam int CH_B  = 3;
    localparam int CH_R  = 4;

`ifdef AXI_PT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // clock / reset
    logic aclk   = 1'b0;
    logic areset = 1'b0;
    always #5 aclk = ~aclk;

    logic [3:0]  s_awid, s_arid, m_awid, m_arid, s_bid, m_bid, s_rid, m_rid;
    logic [31:0] s_awaddr, s_araddr, m_awaddr, m_araddr;
    logic [7:0]  s_awlen, s_arlen, m_awlen, m_arlen;
    logic [2:0]  s_awsize, s_arsize, m_awsize, m_arsize;
    logic [1:0]  s_awburst, s_arburst, m_awburst, m_arburst;
    logic        s_awlock, s_arlock, m_awlock, m_arlock;
    logic [3:0]  s_awcache, s_arcache, m_awcache, m_arcache;
    logic [2:0]  s_awprot, s_arprot, m_awprot, m_arprot;
    logic [3:0]  s_awqos, s_arqos, m_awqos, m_arqos;
    logic        s_awvalid, s_awready, m_awvalid, m_awready;
    logic        s_arvalid, s_arready, m_arvalid, m_arready;
    logic [31:0] s_wdata, m_wdata, s_rdata, m_rdata;
    logic [3:0]  s_wstrb, m_wstrb;
    logic        s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
    logic [1:0]  s_bresp, m_bresp, s_rresp, m_rresp;
    logic        s_bvalid, s_bready, m_bvalid, m_bready;
    logic        s_rlast, m_rlast, s_rvalid, s_rready, m_rvalid, m_rready;
    logic [31:0] wr_done_cnt, rd_done_cnt;

    axi_passthrough_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
        .aclk(aclk), .areset(areset),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awlock(s_awlock), .s_awcache(s_awcache), .s_awprot(s_awprot),
        .s_awqos(s_awqos), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bid(s_bid), .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arlock(s_arlock), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arqos(s_arqos), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
        .m_awqos(m_awqos), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
        .m_arqos(m_arqos), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt)
    );

    // scoreboard / model state
    int n_checks = 0;
    int n_pass   = 0;
    logic [PW-1:0] exp_q[NCH][$];
    logic [PW-1:0] stim_q[NCH][$];
    int unsigned   src_pct[NCH];
    int unsigned   snk_pct[NCH];
    bit            fill[NCH];
    bit            hold[NCH];
    bit            cur_v[NCH];
    logic [PW-1:0] cur_p[NCH];
    logic [31:0]   wr_exp;
    logic [31:0]   rd_exp;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pw_of(input int ch);
        case (ch)
            CH_AW, CH_AR: return 61;
            CH_W:         return 37;
            CH_B:         return 6;
            default:      return 39;
        endcase
    endfunction

    function automatic logic [PW-1:0] rand_payload(input int ch);
        logic [PW-1:0] mask;
        mask = (64'h1 << pw_of(ch)) - 64'h1;
        return {$urandom, $urandom} & mask;
    endfunction

    function automatic logic [PW-1:0] ax_pl(input logic [3:0] id, input logic [31:0] addr,
                                           input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
        return 64'({id, addr, len, size, burst, 1'b0, 4'h3, 3'h0, 4'h0});
    endfunction

    function automatic logic [PW-1:0] w_pl(input logic [31:0] data, input logic [3:0] strb,
                                          input logic last);
        return 64'({data, strb, last});
    endfunction

    function automatic logic [PW-1:0] r_pl(input logic [3:0] id, input logic [31:0] data,
                                          input logic [1:0] resp, input logic last);
        return 64'({id, data, resp, last});
    endfunction

    task automatic set_in(input int ch, input logic v, input logic [PW-1:0] p);
        case (ch)
            CH_AW: begin
                s_awvalid = v;
                {s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awlock, s_awcache,
                 s_awprot, s_awqos} = p[60:0];
            end
            CH_W: begin
                s_wvalid = v;
                {s_wdata, s_wstrb, s_wlast} = p[36:0];
            end
            CH_AR: begin
                s_arvalid = v;
                {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache,
                 s_arprot, s_arqos} = p[60:0];
            end
            CH_B: begin
                m_bvalid = v;
                {m_bid, m_bresp} = p[5:0];
            end
            default: begin
                m_rvalid = v;
                {m_rid, m_rdata, m_rresp, m_rlast} = p[38:0];
            end
        endcase
    endtask

    task automatic set_snk_ready(input int ch, input logic r);
        case (ch)
            CH_AW:   m_awready = r;
            CH_W:    m_wready  = r;
            CH_AR:   m_arready = r;
            CH_B:    s_bready  = r;
            default: s_rready  = r;
        endcase
    endtask

    function automatic logic in_ready_of(input int ch);
        case (ch)
            CH_AW:   return s_awready;
            CH_W:    return s_wready;
            CH_AR:   return s_arready;
            CH_B:    return m_bready;
            default: return m_rready;
        endcase
    endfunction

    function automatic logic out_valid_of(input int ch);
        case (ch)
            CH_AW:   return m_awvalid;
            CH_W:    return m_wvalid;
            CH_AR:   return m_arvalid;
            CH_B:    return s_bvalid;
            default: return s_rvalid;
        endcase
    endfunction

    function automatic logic [PW-1:0] out_data_of(input int ch);
        case (ch)
            CH_AW:   return 64'({m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
                                 m_awcache, m_awprot, m_awqos});
            CH_W:    return 64'({m_wdata, m_wstrb, m_wlast});
            CH_AR:   return 64'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
                                 m_arcache, m_arprot, m_arqos});
            CH_B:    return 64'({s_bid, s_bresp});
            default: return 64'({s_rid, s_rdata, s_rresp, s_rlast});
        endcase
    endfunction

    // One cycle: check outputs at the falling edge, drive new inputs, and predict the next edge.
    task automatic step();
        bit rdy, pushd, popd;
        logic [PW-1:0] pl;
        @(negedge aclk);
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("ch%0d_valid", c), 64'(out_valid_of(c)), 64'(exp_q[c].size() > 0));
            check($sformatf("ch%0d_ready", c), 64'(in_ready_of(c)), 64'(exp_q[c].size() < 2));
            if (exp_q[c].size() > 0) begin
                check($sformatf("ch%0d_data", c), out_data_of(c), exp_q[c][0]);
            end
        end
        check("wr_done_cnt", 64'(wr_done_cnt), 64'(wr_exp));
        check("rd_done_cnt", 64'(rd_done_cnt), 64'(rd_exp));
        for (int c = 0; c < NCH; c++) begin
            if (!hold[c]) begin
                cur_v[c] = 1'b0;
                cur_p[c] = '0;
                if ($urandom_range(99) < src_pct[c]) begin
                    if (stim_q[c].size() > 0) begin
                        pl = stim_q[c].pop_front();
                        cur_v[c] = 1'b1;
                        cur_p[c] = pl;
                    end else if (fill[c]) begin
                        cur_v[c] = 1'b1;
                        cur_p[c] = rand_payload(c);
                    end
                end
            end
            rdy = ($urandom_range(99) < snk_pct[c]);
            set_in(c, cur_v[c], cur_p[c]);
            set_snk_ready(c, rdy);
            popd  = (exp_q[c].size() > 0) && rdy;
            pushd = cur_v[c] && (exp_q[c].size() < 2);
            if (popd) begin
                if (STATS && c == CH_B) wr_exp = wr_exp + 32'd1;
                if (STATS && c == CH_R && exp_q[c][0][0]) rd_exp = rd_exp + 32'd1;
                void'(exp_q[c].pop_front());
            end
            if (pushd) exp_q[c].push_back(cur_p[c]);
            hold[c] = cur_v[c] && !pushd;
        end
    endtask

    task automatic quiet();
        for (int c = 0; c < NCH; c++) begin
            src_pct[c] = 0;
            snk_pct[c] = 100;
            fill[c]    = 1'b0;
        end
    endtask

    // Asynchronous pulse between edges; outputs must drop before any clock edge.
    task automatic pulse_reset();
        #2 areset = 1'b1;
        #1;
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("rst_ch%0d_valid", c), 64'(out_valid_of(c)), 64'd0);
            check($sformatf("rst_ch%0d_ready", c), 64'(in_ready_of(c)), 64'd0);
        end
        check("rst_wr_cnt", 64'(wr_done_cnt), 64'd0);
        check("rst_rd_cnt", 64'(rd_done_cnt), 64'd0);
        for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            stim_q[c].delete();
            hold[c]  = 1'b0;
            cur_v[c] = 1'b0;
            cur_p[c] = '0;
            set_in(c, 1'b0, '0);
            set_snk_ready(c, 1'b0);
        end
        wr_exp = 32'h0;
        rd_exp = 32'h0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
    endtask

    initial begin
        int obs_a, obs_b;
        bit low_seen;
        logic [31:0] got_q[$];
        logic [31:0] last_rdata;

        wr_exp = 32'h0;
        rd_exp = 32'h0;
        for (int c = 0; c < NCH; c++) begin
            hold[c]  = 1'b0;
            cur_v[c] = 1'b0;
            cur_p[c] = '0;
            set_in(c, 1'b0, '0);
            set_snk_ready(c, 1'b0);
        end
        quiet();

        // reset state, then readys rise one edge after release
        pulse_reset();
        step();
        check("t1_awready", 64'(s_awready), 64'd1);
        check("t1_wready", 64'(s_wready), 64'd1);
        check("t1_arready", 64'(s_arready), 64'd1);

        // single write
        stim_q[CH_AW].push_back(ax_pl(4'd0, 32'h1000, 8'd0, 3'd2, INCR));
        stim_q[CH_W].push_back(w_pl(32'hDEADBEEF, 4'hF, 1'b1));
        for (int c = 0; c < NCH; c++) src_pct[c] = 100;
        step();
        step();
        check("t2_awaddr", 64'(m_awaddr), 64'h1000);
        check("t2_awlen", 64'(m_awlen), 64'd0);
        check("t2_awsize", 64'(m_awsize), 64'd2);
        check("t2_awburst", 64'(m_awburst), 64'(INCR));
        check("t2_wdata", 64'(m_wdata), 64'hDEADBEEF);
        check("t2_wstrb", 64'(m_wstrb), 64'hF);
        stim_q[CH_B].push_back(64'({4'd3, OKAY}));
        step();
        step();
        check("t2_bid", 64'(s_bid), 64'd3);
        check("t2_bresp", 64'(s_bresp), 64'(OKAY));
        step();
        step();
        check("t2_wr_cnt", 64'(wr_done_cnt), STATS ? 64'd1 : 64'd0);

        // read burst of 4
        stim_q[CH_AR].push_back(ax_pl(4'd2, 32'h2000, 8'd3, 3'd2, INCR));
        for (int k = 1; k <= 4; k++) begin
            stim_q[CH_R].push_back(r_pl(4'd2, 32'(k * 32'h11), OKAY, k == 4));
        end
        obs_a = 0;
        obs_b = 0;
        last_rdata = '0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (s_rvalid && s_rready) begin
                obs_a++;
                if (s_rlast) begin
                    obs_b++;
                    last_rdata = s_rdata;
                end
            end
        end
        check("t3_rbeats", 64'(obs_a), 64'd4);
        check("t3_rlast_cnt", 64'(obs_b), 64'd1);
        check("t3_rlast_data", 64'(last_rdata), 64'h44);
        check("t3_rd_cnt", 64'(rd_done_cnt), STATS ? 64'd1 : 64'd0);

        // backpressure on W
        quiet();
        src_pct[CH_W] = 100;
        for (int k = 0; k < 8; k++) stim_q[CH_W].push_back(w_pl(32'hA0 + 32'(k), 4'hF, k == 7));
        low_seen = 1'b0;
        got_q.delete();
        for (int c = 0; c < 20; c++) begin
            snk_pct[CH_W] = (c >= 3 && c <= 7) ? 0 : 100;
            step();
            if (!s_wready) low_seen = 1'b1;
            if (m_wvalid && m_wready) got_q.push_back(m_wdata);
        end
        check("t4_wready_dropped", 64'(low_seen), 64'd1);
        check("t4_beats", 64'(got_q.size()), 64'd8);
        for (int k = 0; k < got_q.size(); k++) begin
            check("t4_seq", 64'(got_q[k]), 64'hA0 + 64'(k));
        end

        // async reset in the middle of bursts
        quiet();
        src_pct[CH_W] = 100;
        src_pct[CH_R] = 100;
        snk_pct[CH_W] = 50;
        for (int k = 0; k < 8; k++) begin
            stim_q[CH_W].push_back(w_pl(32'hB0 + 32'(k), 4'hF, k == 7));
            stim_q[CH_R].push_back(r_pl(4'd1, 32'hC0 + 32'(k), OKAY, k == 7));
        end
        repeat (3) step();
        pulse_reset();
        quiet();

        // streaming: 256 back-to-back W beats
        src_pct[CH_W] = 100;
        for (int k = 0; k < 256; k++) stim_q[CH_W].push_back(w_pl($urandom, 4'($urandom), k == 255));
        obs_a = 0;
        obs_b = 0;
        for (int k = 0; k < 257; k++) begin
            step();
            if (s_wvalid && s_wready) obs_a++;
            if (m_wvalid && m_wready) obs_b++;
        end
        check("t6_in_hs", 64'(obs_a), 64'd256);
        check("t6_out_hs", 64'(obs_b), 64'd256);

        // randomized traffic on all channels
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < NCH; c++) begin
                fill[c]    = 1'b1;
                src_pct[c] = $urandom_range(100, 30);
                snk_pct[c] = (ph == 3) ? 100 : $urandom_range(100, 20);
            end
            repeat (250) step();
        end
        quiet();
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
